// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops characters from the TX FIFO and serialises them as
// start/data/parity/stop bits, timing each bit with oversample ticks from bclk_in.
module uart_tx_ctrl #(
  parameter int OSR16 = 16,
  parameter int OSR13 = 13
) (
  input  logic       apb_clk_in,
  input  logic       apb_rstn_in,
  input  logic       bclk_in,
  input  logic       osm_in,
  input  logic       tx_en_in,
  input  logic [1:0] wls_in,
  input  logic       stb_in,
  input  logic       pen_in,
  input  logic       eps_in,
  input  logic       sp_in,
  input  logic       bc_in,
  input  logic       fifo_empty_in,
  input  logic [7:0] fifo_data_in,
  output logic       fifo_rd_out,
  output logic       uart_txd_out,
  output logic       busy_out,
  output logic       temt_out,
  output logic       char_done_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [4:0] LEN16  = 5'(OSR16);
  localparam logic [4:0] LEN13  = 5'(OSR13);
  // Second half of a 1.5-bit stop: 24 - 16 = 8 ticks, 20 - 13 = 7 ticks.
  localparam logic [4:0] HALF16 = 5'((OSR16 + 1) / 2);
  localparam logic [4:0] HALF13 = 5'((OSR13 + 1) / 2);

  state_t     state_r, state_n_s;
  logic [4:0] tick_cnt_r, tick_cnt_n_s;
  logic [2:0] bit_cnt_r, bit_cnt_n_s;
  logic       stop_seg_r, stop_seg_n_s;
  logic [7:0] shift_r, shift_n_s;
  logic       txd_r, txd_n_s;
  logic       busy_r;
  logic       done_r, done_n_s;
  logic [1:0] wls_r;
  logic       stb_r, pen_r, osm_r, par_r;
  logic       load_s, tick_end_s, last_bit_s;
  logic [4:0] seg_len_s;

  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    logic [7:0] mask;
    logic       x;
    case (wls)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
    x = ^(data & mask);
    if (sp) begin
      parity_bit = ~eps;
    end else if (eps) begin
      parity_bit = x;
    end else begin
      parity_bit = ~x;
    end
  endfunction

  assign load_s     = apb_rstn_in && tx_en_in && !fifo_empty_in && (state_r == IDLE);
  assign tick_end_s = bclk_in && ((tick_cnt_r + 5'd1) == seg_len_s);
  assign last_bit_s = (bit_cnt_r == (3'd4 + {1'b0, wls_r}));

  // Length in ticks of the segment currently being timed.
  always_comb begin
    seg_len_s = osm_r ? LEN13 : LEN16;
    if ((state_r == STOP) && stop_seg_r && (wls_r == 2'b00)) begin
      seg_len_s = osm_r ? HALF13 : HALF16;
    end else begin
      seg_len_s = osm_r ? LEN13 : LEN16;
    end
  end

  // Next-state, counter and line-level decode.
  always_comb begin
    state_n_s    = state_r;
    tick_cnt_n_s = tick_cnt_r;
    bit_cnt_n_s  = bit_cnt_r;
    stop_seg_n_s = stop_seg_r;
    shift_n_s    = shift_r;
    done_n_s     = 1'b0;
    txd_n_s      = 1'b1;
    if (!tx_en_in) begin
      state_n_s    = IDLE;
      tick_cnt_n_s = 5'd0;
      bit_cnt_n_s  = 3'd0;
      stop_seg_n_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_n_s    = START;
            tick_cnt_n_s = 5'd0;
            bit_cnt_n_s  = 3'd0;
            stop_seg_n_s = 1'b0;
            shift_n_s    = fifo_data_in;
          end else begin
            state_n_s = IDLE;
          end
        end
        START, PARITY: begin
          if (tick_end_s) begin
            tick_cnt_n_s = 5'd0;
            state_n_s    = (state_r == START) ? DATA : STOP;
          end else if (bclk_in) begin
            tick_cnt_n_s = tick_cnt_r + 5'd1;
          end else begin
            tick_cnt_n_s = tick_cnt_r;
          end
        end
        DATA: begin
          if (tick_end_s) begin
            tick_cnt_n_s = 5'd0;
            if (last_bit_s) begin
              state_n_s = pen_r ? PARITY : STOP;
            end else begin
              bit_cnt_n_s = bit_cnt_r + 3'd1;
              shift_n_s   = {1'b0, shift_r[7:1]};
            end
          end else if (bclk_in) begin
            tick_cnt_n_s = tick_cnt_r + 5'd1;
          end else begin
            tick_cnt_n_s = tick_cnt_r;
          end
        end
        STOP: begin
          if (tick_end_s) begin
            tick_cnt_n_s = 5'd0;
            if (stb_r && !stop_seg_r) begin
              stop_seg_n_s = 1'b1;
            end else begin
              stop_seg_n_s = 1'b0;
              state_n_s    = IDLE;
              done_n_s     = 1'b1;
            end
          end else if (bclk_in) begin
            tick_cnt_n_s = tick_cnt_r + 5'd1;
          end else begin
            tick_cnt_n_s = tick_cnt_r;
          end
        end
        default: begin
          state_n_s    = IDLE;
          tick_cnt_n_s = 5'd0;
        end
      endcase
    end
    // Line level follows the state being entered so txd and busy move together.
    case (state_n_s)
      START:   txd_n_s = 1'b0;
      DATA:    txd_n_s = shift_n_s[0];
      PARITY:  txd_n_s = par_r;
      default: txd_n_s = 1'b1;
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      state_r    <= IDLE;
      tick_cnt_r <= 5'd0;
      bit_cnt_r  <= 3'd0;
      stop_seg_r <= 1'b0;
      shift_r    <= 8'h00;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      tick_cnt_r <= tick_cnt_n_s;
      bit_cnt_r  <= bit_cnt_n_s;
      stop_seg_r <= stop_seg_n_s;
      shift_r    <= shift_n_s;
      txd_r      <= txd_n_s;
      busy_r     <= (state_n_s != IDLE);
      done_r     <= done_n_s;
    end
  end

  // Frame format snapshot; parity is resolved at load so eps/sp need no shadow.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      wls_r <= 2'b00;
      stb_r <= 1'b0;
      pen_r <= 1'b0;
      osm_r <= 1'b0;
      par_r <= 1'b0;
    end else if (load_s) begin
      wls_r <= wls_in;
      stb_r <= stb_in;
      pen_r <= pen_in;
      osm_r <= osm_in;
      par_r <= parity_bit(fifo_data_in, wls_in, eps_in, sp_in);
    end else begin
      wls_r <= wls_r;
      stb_r <= stb_r;
      pen_r <= pen_r;
      osm_r <= osm_r;
      par_r <= par_r;
    end
  end

  assign fifo_rd_out   = load_s;
  assign uart_txd_out  = txd_r & ~bc_in;
  assign busy_out      = busy_r;
  assign temt_out      = (state_r == IDLE) && fifo_empty_in;
  assign char_done_out = done_r;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a FIFO model feeds bytes, and every counted bclk
// tick's line level is compared against a per-tick bit stream built from the frame rules.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, bclk, osm, tx_en, stb, pen, eps, sp, bc, fifo_empty;
  logic [1:0] wls;
  logic [7:0] fifo_data;
  logic       fifo_rd, txd, busy, temt, done;

  logic [7:0] fifo_q[$];
  logic       exp_q[$];
  int n_vec = 0, n_err = 0;
  int frame_active = 0, ticks_in_frame = 0, last_frame_ticks = 0;
  int pops = 0, dones = 0, bgap = 0, snap;
  logic pop_pend = 1'b0;

  uart_tx_ctrl dut (
    .apb_clk_in(clk), .apb_rstn_in(rst_n), .bclk_in(bclk), .osm_in(osm),
    .tx_en_in(tx_en), .wls_in(wls), .stb_in(stb), .pen_in(pen), .eps_in(eps),
    .sp_in(sp), .bc_in(bc), .fifo_empty_in(fifo_empty), .fifo_data_in(fifo_data),
    .fifo_rd_out(fifo_rd), .uart_txd_out(txd), .busy_out(busy), .temt_out(temt),
    .char_done_out(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh_fifo();
  endtask

  task automatic push_bits(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Reference frame as one line level per oversample tick, from the current config.
  task automatic add_frame(input logic [7:0] b);
    int nt, nb, ones, stop_len;
    logic bv;
    nt = osm ? 13 : 16;
    nb = 5 + int'(wls);
    ones = 0;
    push_bits(1'b0, nt);
    for (int i = 0; i < nb; i++) begin
      bv = b[i];
      ones += int'(bv);
      push_bits(bv, nt);
    end
    if (pen) begin
      if (sp) push_bits(!eps, nt);
      else if (eps) push_bits(1'((ones % 2)), nt);
      else push_bits(1'((ones + 1) % 2), nt);
    end
    if (!stb) stop_len = nt;
    else if (wls == 2'b00) stop_len = osm ? 20 : 24;
    else stop_len = 2 * nt;
    push_bits(1'b1, stop_len);
  endtask

  task automatic monitor();
    logic e;
    if (!rst_n) return;
    if (done) begin
      dones++;
      last_frame_ticks = ticks_in_frame;
      chk("done_unexpected", frame_active, 1);
      chk("frame_len_left", exp_q.size(), 0);
      chk("gap_pop", int'(fifo_rd), int'(tx_en && !fifo_empty));
      frame_active = 0;
    end
    chk("busy", int'(busy), frame_active);
    chk("temt", int'(temt), int'(!busy && fifo_empty));
    if (!busy && !bc) chk("idle_txd", int'(txd), 1);
    if (busy && bclk && tx_en) begin
      chk("tick_overrun", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("txd_bit", int'(txd), int'(e & ~bc));
      end
      ticks_in_frame++;
    end
    if (!tx_en) begin
      exp_q.delete();
      frame_active = 0;
    end
    if (fifo_rd) begin
      chk("rd_while_empty", int'(fifo_empty), 0);
      chk("pop_overlap", frame_active, 0);
      add_frame(fifo_data);
      frame_active = 1;
      ticks_in_frame = 0;
      pops++;
      pop_pend = 1'b1;
    end
  endtask

  // One clock: sample at the falling edge, then apply the pop and new bclk after the rise.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (pop_pend) begin
      void'(fifo_q.pop_front());
      pop_pend = 1'b0;
    end
    refresh_fifo();
    if (bgap == 0) begin
      bclk = 1'b1;
      bgap = $urandom_range(0, 2);
    end else begin
      bclk = 1'b0;
      bgap--;
    end
  endtask

  task automatic set_cfg(input logic o, input logic [1:0] w, input logic s,
                         input logic p, input logic e, input logic spv);
    osm = o; wls = w; stb = s; pen = p; eps = e; sp = spv;
  endtask

  task automatic rand_cfg();
    set_cfg(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_idle(input string tag, input int max, input logic rnd);
    int ok;
    ok = 0;
    for (int c = 0; c < max; c++) begin
      step();
      if (rnd && ($urandom_range(0, 199) == 0)) rand_cfg();
      if (fifo_q.size() == 0 && !busy && frame_active == 0) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  task automatic wait_ticks(input string tag, input int target);
    int ok;
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (ticks_in_frame >= target && frame_active == 1) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    rst_n = 1'b0; bclk = 1'b0; tx_en = 1'b0; bc = 1'b0;
    set_cfg(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    refresh_fifo();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", int'(txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd", int'(fifo_rd), 0);
    chk("rst_temt", int'(temt), 1);
    rst_n = 1'b1;
    tx_en = 1'b1;
    step();

    // 8N1 0x55 at 16x
    snap = pops; push(8'h55);
    run_idle("t1_idle", 2000, 1'b0);
    chk("t1_pops", pops - snap, 1);
    chk("t1_ticks", last_frame_ticks, 160);
    chk("t1_temt", int'(temt), 1);

    // 5 bits, 1.5 stop at 16x then 13x
    set_cfg(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h1F);
    run_idle("t2a_idle", 2000, 1'b0);
    chk("t2a_ticks", last_frame_ticks, 120);
    osm = 1'b1;
    push(8'h1F);
    run_idle("t2b_idle", 2000, 1'b0);
    chk("t2b_ticks", last_frame_ticks, 98);

    // Parity modes on 0x07
    for (int m = 0; m < 4; m++) begin
      set_cfg(1'b0, 2'b11, 1'b0, 1'b1, 1'(m == 0 || m == 2), 1'(m >= 2));
      push(8'h07);
      run_idle("t3_idle", 2000, 1'b0);
      chk("t3_ticks", last_frame_ticks, 176);
    end

    // Back-to-back frames from a preloaded FIFO
    set_cfg(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    snap = dones;
    tx_en = 1'b0;
    push(8'hA5); push(8'h3C);
    step();
    tx_en = 1'b1;
    snap = pops;
    run_idle("t4_idle", 3000, 1'b0);
    chk("t4_pops", pops - snap, 2);
    chk("t4_temt", int'(temt), 1);

    // Abort during the 3rd data bit, then resume with the queued byte
    push(8'hC3); push(8'h5A);
    snap = dones;
    wait_ticks("t5_wait", 16 * 3 + 5);
    tx_en = 1'b0;
    step();
    chk("t5_busy", int'(busy), 0);
    chk("t5_txd", int'(txd), 1);
    repeat (4) step();
    chk("t5_no_done", dones - snap, 0);
    snap = pops;
    tx_en = 1'b1;
    step();
    step();
    chk("t5_repop", pops - snap, 1);
    run_idle("t5_idle", 2000, 1'b0);

    // Break held for 40 ticks inside DATA
    push(8'h96);
    wait_ticks("t6_wait", 20);
    bc = 1'b1;
    step();
    chk("t6_brk_txd", int'(txd), 0);
    wait_ticks("t6_hold", 60);
    bc = 1'b0;
    run_idle("t6_idle", 2000, 1'b0);
    chk("t6_ticks", last_frame_ticks, 160);

    // Async reset mid-frame
    push(8'h81);
    wait_ticks("t7_wait", 30);
    snap = pops;
    rst_n = 1'b0;
    #1;
    chk("t7_txd", int'(txd), 1);
    chk("t7_busy", int'(busy), 0);
    exp_q.delete();
    frame_active = 0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("t7_no_repop", pops - snap, 0);

    // Random formats, bytes and mid-frame config churn
    for (int f = 0; f < 20; f++) begin
      rand_cfg();
      snap = $urandom_range(1, 3);
      for (int k = 0; k < snap; k++) push(8'($urandom_range(0, 255)));
      run_idle("rand_idle", 4000, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
